knight_seq: RTL and testbench

KNIGHT_SEQ -- requirements
Module: knight_seq

---
 rtl/knight_seq.sv | 127 ++++++++++++
 tb/tb_knight_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/knight_seq.sv
// ============================================================================
// knight_seq: knight-rider lamp sequencer, bouncing a single lit lamp 0..7..0
// at a programmable step period, with hold, abort, restart and one-shot modes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module knight_seq #(
  parameter int PRE_W = 16
) (
  input  logic             ck,
  input  logic             res,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             oneshot,
  input  logic [PRE_W-1:0] div,
  output logic [7:0]       out,
  output logic [2:0]       pos,
  output logic             dir,
  output logic             step,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state, w_state_n;
  logic [3:0]       r_ph, w_ph_n;
  logic [PRE_W-1:0] r_pre, w_pre_n;
  logic [PRE_W-1:0] r_div, w_div_n;
  logic             r_os, w_os_n;
  logic             w_step_n, w_done_n;
  logic [2:0]       w_pos_n;

  always_ff @(posedge ck or negedge res) begin
    if (!res) r_state <= S_IDLE;
    else      r_state <= w_state_n;
  end

  // Abort outranks restart, which outranks hold and normal counting.
  always_comb begin
    w_state_n = r_state;
    w_ph_n    = r_ph;
    w_pre_n   = r_pre;
    w_div_n   = r_div;
    w_os_n    = r_os;
    w_step_n  = 1'b0;
    w_done_n  = 1'b0;
    if (stop) begin
      w_state_n = S_IDLE;
      w_ph_n    = 4'd0;
      w_pre_n   = '0;
    end else if (start) begin
      w_state_n = S_RUN;
      w_ph_n    = 4'd0;
      w_pre_n   = '0;
      w_div_n   = div;
      w_os_n    = oneshot;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_n = S_IDLE;
        S_HOLD: if (!hold) w_state_n = S_RUN;
        S_RUN: begin
          if (hold) begin
            w_state_n = S_HOLD;
          end else if (r_pre == r_div) begin
            w_pre_n = '0;
            if (r_os && (r_ph == 4'd15)) begin
              w_state_n = S_IDLE;
              w_ph_n    = 4'd0;
              w_done_n  = 1'b1;
            end else begin
              w_ph_n   = r_ph + 4'd1;
              w_step_n = 1'b1;
            end
          end else begin
            w_pre_n = r_pre + 1'b1;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // Down half of the sweep mirrors the lamp index so both ends dwell two steps.
  assign w_pos_n = w_ph_n[3] ? ~w_ph_n[2:0] : w_ph_n[2:0];

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      r_ph  <= 4'd0;
      r_pre <= '0;
      r_div <= '0;
      r_os  <= 1'b0;
      out   <= 8'd0;
      pos   <= 3'd0;
      dir   <= 1'b0;
      step  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      r_ph  <= w_ph_n;
      r_pre <= w_pre_n;
      r_div <= w_div_n;
      r_os  <= w_os_n;
      step  <= w_step_n;
      done  <= w_done_n;
      busy  <= (w_state_n != S_IDLE);
      if (w_state_n == S_IDLE) begin
        out <= 8'd0;
        pos <= 3'd0;
        dir <= 1'b0;
      end else begin
        out <= 8'd1 << w_pos_n;
        pos <= w_pos_n;
        dir <= w_ph_n[3];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_knight_seq.sv
// ============================================================================
// tb_knight_seq: directed self-checking bench for knight_seq (PRE_W = 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_knight_seq;

  localparam int PRE_W = 4;

  logic             ck;
  logic             res;
  logic             start;
  logic             stop;
  logic             hold;
  logic             oneshot;
  logic [PRE_W-1:0] div;
  logic [7:0]       out;
  logic [2:0]       pos;
  logic             dir;
  logic             step;
  logic             busy;
  logic             done;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  knight_seq #(.PRE_W(PRE_W)) dut (
    .ck      (ck),
    .res     (res),
    .start   (start),
    .stop    (stop),
    .hold    (hold),
    .oneshot (oneshot),
    .div     (div),
    .out     (out),
    .pos     (pos),
    .dir     (dir),
    .step    (step),
    .busy    (busy),
    .done    (done)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tot++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Packed as {out, pos, dir, step, busy, done}.
  task automatic chk_all(input string tag, input logic [7:0] e_out, input logic [2:0] e_pos,
                         input logic e_dir, input logic e_step, input logic e_busy,
                         input logic e_done);
    chk(tag, {17'd0, out, pos, dir, step, busy, done},
        {17'd0, e_out, e_pos, e_dir, e_step, e_busy, e_done});
  endtask

  logic [7:0] ea_out [18] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01, 8'h02};
  logic [2:0] ea_pos [18] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7,
                              3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1};
  logic       ea_dir [18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int nstep;
    res = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; oneshot = 1'b0; div = '0;
    #2;
    chk_all("rst_state", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; div = 4'd5; oneshot = 1'b1;
    tick();
    start = 1'b0;
    chk_all("rst_ignores_start", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    res = 1'b1;
    tick();
    hold = 1'b1; stop = 1'b1;
    tick();
    hold = 1'b0; stop = 1'b0;
    chk_all("idle_ignores_hold_stop", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Continuous sweep, step every cycle
    div = 4'd0; oneshot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("a_first", 8'h01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < 18; k++) begin
      tick();
      chk_all($sformatf("a_k%0d", k), ea_out[k], ea_pos[k], ea_dir[k], 1'b1, 1'b1, 1'b0);
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk_all("a_start_stop", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("a_no_done", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Restart mid-sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("rs_mid_out", {24'd0, out}, 32'h08);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("rs_restart", 8'h01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("rs_stop", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // One-shot, period 4; div/oneshot changes afterwards must not matter
    div = 4'd3; oneshot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("b_first", 8'h01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    div = 4'd0; oneshot = 1'b0;
    nstep = 0;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (step) nstep++;
      chk($sformatf("b_step_k%0d", k), {31'd0, step}, {31'd0, ((k % 4) == 0) && (k < 64)});
      chk($sformatf("b_done_k%0d", k), {31'd0, done}, {31'd0, k == 64});
      chk($sformatf("b_busy_k%0d", k), {31'd0, busy}, {31'd0, k < 64});
      if (k == 32) chk_all("b_k32", 8'h80, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0);
      if (k == 64) chk("b_end_out", {24'd0, out}, 32'h00);
    end
    chk("b_nsteps", nstep, 15);

    // Hold at pos 5, period 3
    div = 4'd2; oneshot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    tick();
    chk_all("h_pos5", 8'h20, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("h_pre1", 8'h20, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_all($sformatf("h_held%0d", k), 8'h20, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    hold = 1'b0;
    tick();
    chk_all("h_release", 8'h20, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("h_resume1", 8'h20, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("h_resume_step", 8'h40, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0);

    // Restart while held
    hold = 1'b1;
    tick();
    div = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("hr_restart", 8'h01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("hr_reheld", 8'h01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    hold = 1'b0;
    tick();
    chk_all("hr_release", 8'h01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("hr_step", 8'h02, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-sweep
    tick();
    chk("ar_pre_out", {24'd0, out}, 32'h04);
    #3;
    res = 1'b0;
    #1;
    chk_all("ar_immediate", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    res = 1'b1;
    tick(); tick();
    chk_all("ar_stay_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // All-ones divider: 16-cycle step period
    div = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    tick();
    chk_all("m_c15", 8'h01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("m_c16", 8'h02, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("m_stop", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
